waveform_meter: RTL and testbench

//  Receive-side measurement block for the DDS DAC path. Takes the 16-bit unsigned sample stream
//  (DAC loopback or ADC capture) and measures the period, peak-to-peak amplitude and DC level.

---
 rtl/waveform_meter.sv | 146 ++++++++++++++
 tb/tb_waveform_meter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/waveform_meter.sv
// waveform_meter: measures period, peak-to-peak and DC level of an unsigned sample stream.
// Define WAVEFORM_METER_AUTOTHR_EN to reuse the last measured DC level as the crossing level.
module waveform_meter #(
  parameter int DATA_W      = 16,
  parameter int CYC_W       = 32,
  parameter int NUM_PERIODS = 4,
  parameter int HYST        = 64,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] thr,
  output logic              busy,
  output logic              meas_valid,
  output logic [CYC_W-1:0]  meas_period,
  output logic [DATA_W-1:0] meas_pp,
  output logic [DATA_W-1:0] meas_dc,
  output logic              err_timeout
);
  localparam int SH    = $clog2(NUM_PERIODS);
  localparam int CNT_W = $clog2(NUM_PERIODS + 1);
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;
  state_t r_state, w_next;

  logic [DATA_W-1:0] r_smp, r_hi, r_lo, r_min, r_max, r_pp, r_dc;
  logic              r_sv, r_arm, r_mv, r_err;
  logic [CYC_W-1:0]  r_cyc, r_period;
  logic [CNT_W-1:0]  r_cnt;
  logic [TO_W-1:0]   r_to;

  logic [DATA_W-1:0] w_lvl, w_hi, w_lo, w_min, w_max;
  logic [DATA_W:0]   w_hi_sum, w_sum;
  logic [CYC_W-1:0]  w_cyc_inc;
  logic              w_accept, w_act, w_low, w_rise, w_tmo, w_last;

`ifdef WAVEFORM_METER_AUTOTHR_EN
  logic [DATA_W-1:0] r_lvl;
  logic              r_have;
  assign w_lvl = r_have ? r_lvl : thr;
`else
  assign w_lvl = thr;
`endif

  assign w_hi_sum  = {1'b0, w_lvl} + (DATA_W+1)'(HYST);
  assign w_hi      = w_hi_sum[DATA_W] ? '1 : w_hi_sum[DATA_W-1:0];
  assign w_lo      = (w_lvl >= DATA_W'(HYST)) ? w_lvl - DATA_W'(HYST) : '0;
  assign w_accept  = (r_state == IDLE) && start;
  assign w_act     = (r_state == ARM) || (r_state == MEAS);
  assign w_low     = r_sv && (r_smp <= r_lo);
  assign w_rise    = r_sv && r_arm && (r_smp >= r_hi);
  assign w_tmo     = w_act && (r_to == TO_W'(TIMEOUT_CYC - 1));
  assign w_last    = (r_state == MEAS) && w_rise && (r_cnt == CNT_W'(NUM_PERIODS - 1));
  assign w_cyc_inc = (&r_cyc) ? r_cyc : r_cyc + 1'b1;
  assign w_min     = (r_sv && r_smp < r_min) ? r_smp : r_min;
  assign w_max     = (r_sv && r_smp > r_max) ? r_smp : r_max;
  assign w_sum     = {1'b0, w_max} + {1'b0, w_min};

  assign busy        = w_act;
  assign meas_valid  = r_mv;
  assign err_timeout = r_err;
  assign meas_period = r_period;
  assign meas_pp     = r_pp;
  assign meas_dc     = r_dc;

  // a final crossing wins over a coincident timeout in MEAS
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? ARM : IDLE;
      ARM:     w_next = w_tmo ? IDLE : (w_rise ? MEAS : ARM);
      MEAS:    w_next = w_last ? DONE : (w_tmo ? IDLE : MEAS);
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_smp    <= '0;
      r_sv     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_arm    <= 1'b0;
      r_cyc    <= '0;
      r_cnt    <= '0;
      r_to     <= '0;
      r_min    <= '1;
      r_max    <= '0;
      r_mv     <= 1'b0;
      r_err    <= 1'b0;
      r_period <= '0;
      r_pp     <= '0;
      r_dc     <= '0;
`ifdef WAVEFORM_METER_AUTOTHR_EN
      r_lvl    <= '0;
      r_have   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_sv    <= sample_valid;
      if (sample_valid) r_smp <= sample_data;
      r_mv    <= w_last;
      r_err   <= w_tmo && !w_last;
      if (w_accept) begin
        r_hi  <= w_hi;
        r_lo  <= w_lo;
        r_arm <= 1'b0;
        r_cyc <= '0;
        r_cnt <= '0;
        r_to  <= '0;
        r_min <= '1;
        r_max <= '0;
      end else if (w_act) begin
        r_to  <= r_to + 1'b1;
        r_arm <= w_rise ? 1'b0 : (w_low ? 1'b1 : r_arm);
        if (r_state == ARM) begin
          if (w_rise) begin
            r_cyc <= '0;
            r_cnt <= '0;
            r_min <= r_smp;
            r_max <= r_smp;
          end
        end else begin
          r_cyc <= w_cyc_inc;
          r_min <= w_min;
          r_max <= w_max;
          if (w_rise) r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_last) begin
        r_period <= w_cyc_inc >> SH;
        r_pp     <= w_max - w_min;
        r_dc     <= w_sum[DATA_W:1];
`ifdef WAVEFORM_METER_AUTOTHR_EN
        r_lvl    <= w_sum[DATA_W:1];
        r_have   <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_waveform_meter.sv
// tb_waveform_meter: directed checks of waveform_meter on triangle, sparse, noisy and flat inputs.
module tb_waveform_meter;
  localparam int TO = 8192;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sample_valid = 1'b0;
  logic [15:0] sample_data = '0, thr = '0;
  logic        busy, meas_valid, err_timeout;
  logic [31:0] meas_period;
  logic [15:0] meas_pp, meas_dc;

  int checks = 0, errors = 0;
  int cyc_n = 0, ph = 0, mode = 0, nv = 0, ne = 0, t_mv = 0, t_err = 0;
  bit sparse = 1'b0, m_on = 1'b0, m_arm = 1'b0;
  int m_cross = 0, m_last = -1;
  logic [15:0] m_hi = '0, m_lo = '0;

  waveform_meter #(.TIMEOUT_CYC(TO)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .sample_data(sample_data), .thr(thr), .busy(busy), .meas_valid(meas_valid),
    .meas_period(meas_period), .meas_pp(meas_pp), .meas_dc(meas_dc),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tri_v(input int p);
    return (p < 512) ? 16'(4096 + 48 * p) : 16'(28672 - 48 * (p - 512));
  endfunction

  // reference crossing detector: records when the 5th rising crossing sample is driven
  task automatic model();
    if (m_on && sample_valid) begin
      if (sample_data <= m_lo) m_arm = 1'b1;
      else if (sample_data >= m_hi && m_arm) begin
        m_arm = 1'b0;
        m_cross++;
        if (m_cross == 5) m_last = cyc_n;
      end
    end
  endtask

  task automatic drive();
    logic [15:0] v;
    ph = (ph + 1) % 1024;
    v = (mode == 1) ? 16'h4000 : tri_v(ph);
    if (mode == 2 && v > 16'h3F00 && v < 16'h4100) v = (cyc_n % 2 == 1) ? v + 16'd32 : v - 16'd32;
    sample_valid = !sparse || (ph % 2 == 0);
    sample_data  = sample_valid ? v : 16'hFFFF;
    model();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (meas_valid) begin nv++; t_mv = cyc_n; end
    if (err_timeout) begin ne++; t_err = cyc_n; end
    drive();
  endtask

  task automatic do_start(input logic [15:0] t, input logic [15:0] lvl);
    thr = t;
    start = 1'b1;
    m_hi = lvl + 16'd64;
    m_lo = lvl - 16'd64;
    m_arm = 1'b0;
    m_cross = 0;
    m_last = -1;
    m_on = 1'b1;
    model();
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until(input int budget, output int k);
    int nv0, ne0;
    nv0 = nv;
    ne0 = ne;
    k = 0;
    while (nv == nv0 && ne == ne0 && k < budget) begin
      cyc();
      k++;
    end
  endtask

  task automatic measure(input string tag, input logic [15:0] t, input logic [15:0] lvl);
    int k, nv0, ne0;
    nv0 = nv;
    ne0 = ne;
    do_start(t, lvl);
    chk({tag, " busy_after_start"}, busy, 1);
    run_until(7000, k);
    chk({tag, " done_in_budget"}, k < 7000, 1);
    chk({tag, " valid_pulses"}, nv - nv0, 1);
    chk({tag, " no_timeout"}, ne - ne0, 0);
    chk({tag, " busy_in_done"}, busy, 0);
    chk({tag, " period"}, meas_period, 1024);
    chk({tag, " pp"}, meas_pp, 16'h6000);
    chk({tag, " dc"}, meas_dc, 16'h4000);
    chk({tag, " latency"}, t_mv, m_last + 2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk({tag, " start_in_done_ignored"}, busy, 0);
    chk({tag, " valid_one_cycle"}, meas_valid, 0);
  endtask

  initial begin
    int k, nv0, ne0, e_s;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset meas_valid", meas_valid, 0);
    chk("reset err_timeout", err_timeout, 0);
    chk("reset period", meas_period, 0);
    chk("reset pp", meas_pp, 0);
    chk("reset dc", meas_dc, 0);
    rst = 1'b0;
    repeat (5) cyc();

    measure("T1", 16'h4000, 16'h4000);
    sparse = 1'b1;
    measure("T2", 16'h4000, 16'h4000);
    sparse = 1'b0;
    mode = 2;
    measure("T4", 16'h4000, 16'h4000);

    mode = 1;
    nv0 = nv;
    ne0 = ne;
    do_start(16'h4000, 16'h4000);
    e_s = cyc_n;
    run_until(TO + 500, k);
    chk("T3 timeout_pulses", ne - ne0, 1);
    chk("T3 timeout_time", t_err - e_s, TO);
    chk("T3 no_valid", nv - nv0, 0);
    chk("T3 busy_after", busy, 0);
    chk("T3 period_kept", meas_period, 1024);
    chk("T3 pp_kept", meas_pp, 16'h6000);
    chk("T3 dc_kept", meas_dc, 16'h4000);
    cyc();
    chk("T3 err_one_cycle", err_timeout, 0);
    mode = 0;

    nv0 = nv;
    ne0 = ne;
    do_start(16'h4000, 16'h4000);
    repeat (2000) cyc();
    chk("T5 busy_mid", busy, 1);
    thr = 16'h0000;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("T5 busy_after_restart", busy, 1);
    run_until(7000, k);
    chk("T5 valid_pulses", nv - nv0, 1);
    chk("T5 no_timeout", ne - ne0, 0);
    chk("T5 period", meas_period, 1024);
    chk("T5 pp", meas_pp, 16'h6000);
    chk("T5 dc", meas_dc, 16'h4000);
    chk("T5 latency", t_mv, m_last + 2);

    thr = 16'h4000;
    repeat (10) cyc();
    nv0 = nv;
    ne0 = ne;
    do_start(16'h4000, 16'h4000);
    repeat (2000) cyc();
    rst = 1'b1;
    #1;
    chk("T5r busy", busy, 0);
    chk("T5r meas_valid", meas_valid, 0);
    chk("T5r err_timeout", err_timeout, 0);
    chk("T5r period", meas_period, 0);
    chk("T5r pp", meas_pp, 0);
    chk("T5r dc", meas_dc, 0);
    repeat (2) cyc();
    rst = 1'b0;
    m_on = 1'b0;
    repeat (TO + 200) cyc();
    chk("T5r no_valid", nv - nv0, 0);
    chk("T5r no_timeout", ne - ne0, 0);
    chk("T5r busy_idle", busy, 0);

`ifdef WAVEFORM_METER_AUTOTHR_EN
    measure("T6a", 16'h2000, 16'h2000);
    measure("T6b", 16'h0000, 16'h4000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
